// File: rtl/dct8_transpose_buf.sv
// Ping-pong N x N transpose buffer between the row and column 1-D DCT passes.
// Blocks stream in row-major and replay column-major (transpose) or row-major.
module dct8_transpose_buf #(
    parameter int DATA_W = 16,
    parameter int N      = 8,
    parameter int LOG2N  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sync_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_transpose,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [1:0]        bank_busy
);
    localparam int AW    = 2 * LOG2N;
    localparam int DEPTH = N * N;
    localparam logic [AW-1:0] LAST = '1;

    localparam logic [1:0] S_EMPTY    = 2'd0;
    localparam logic [1:0] S_FILLING  = 2'd1;
    localparam logic [1:0] S_FULL     = 2'd2;
    localparam logic [1:0] S_DRAINING = 2'd3;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [DATA_W-1:0] mem [2*DEPTH];
    logic [1:0][1:0]   st;
    logic [1:0]        mode;
    logic              wr_bank, rd_bank, init_done;
    logic [AW-1:0]     wr_cnt, rd_cnt, rd_addr;

    logic [DATA_W-1:0] rd_q;
    logic              rd_last_q, pending;
    entry_t            fifo [2];
    logic              wp, rp;
    logic [1:0]        occ, level;
    entry_t            head;
    logic              wr_fire, rd_fire, pop, push, fpop;

    assign in_ready = init_done & ~sync_clr & ~st[wr_bank][1];
    assign wr_fire  = in_valid & in_ready;

    assign out_valid = (occ != 2'd0) | pending;
    assign pop       = out_valid & out_ready;
    assign level     = occ + {1'b0, pending};
    // FULL and DRAINING both have the upper state bit set
    assign rd_fire   = ~sync_clr & st[rd_bank][1] &
                       ((level < 2'd2) | ((level == 2'd2) & pop));
    assign rd_addr   = mode[rd_bank] ? {rd_cnt[LOG2N-1:0], rd_cnt[AW-1:LOG2N]} : rd_cnt;

    // With an empty FIFO the in-flight read register is the head, so data
    // reaches the output one cycle after issue.
    assign head      = (occ != 2'd0) ? fifo[rp] : entry_t'{rd_last_q, rd_q};
    assign out_data  = head.data;
    assign out_last  = head.last;
    assign fpop      = pop & (occ != 2'd0);
    assign push      = pending & ~(pop & (occ == 2'd0));
    assign bank_busy = {|st[1], |st[0]};

    always_ff @(posedge clk) begin
        if (wr_fire) mem[{wr_bank, wr_cnt}] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done <= 1'b0;
            st        <= {S_EMPTY, S_EMPTY};
            mode      <= 2'b00;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
        end else begin
            init_done <= 1'b1;
            if (sync_clr) begin
                st      <= {S_EMPTY, S_EMPTY};
                mode    <= 2'b00;
                wr_bank <= 1'b0;
                rd_bank <= 1'b0;
                wr_cnt  <= '0;
                rd_cnt  <= '0;
            end else begin
                // Writer and reader never own the same busy bank, so these never collide
                if (wr_fire) begin
                    wr_cnt <= wr_cnt + 1'b1;
                    if (wr_cnt == '0) begin
                        st[wr_bank]   <= S_FILLING;
                        mode[wr_bank] <= in_transpose;
                    end
                    if (wr_cnt == LAST) begin
                        st[wr_bank] <= S_FULL;
                        wr_bank     <= ~wr_bank;
                    end
                end
                if (rd_fire) begin
                    rd_cnt <= rd_cnt + 1'b1;
                    if (rd_cnt == LAST) begin
                        st[rd_bank] <= S_EMPTY;
                        rd_bank     <= ~rd_bank;
                    end else begin
                        st[rd_bank] <= S_DRAINING;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q      <= '0;
            rd_last_q <= 1'b0;
            pending   <= 1'b0;
            occ       <= 2'd0;
            wp        <= 1'b0;
            rp        <= 1'b0;
            fifo[0]   <= '0;
            fifo[1]   <= '0;
        end else if (sync_clr) begin
            pending <= 1'b0;
            occ     <= 2'd0;
            wp      <= 1'b0;
            rp      <= 1'b0;
        end else begin
            if (rd_fire) begin
                rd_q      <= mem[{rd_bank, rd_addr}];
                rd_last_q <= (rd_cnt == LAST);
            end
            pending <= rd_fire;
            if (push) begin
                fifo[wp] <= entry_t'{rd_last_q, rd_q};
                wp       <= ~wp;
            end
            if (fpop) rp <= ~rp;
            occ <= occ + {1'b0, push} - {1'b0, fpop};
        end
    end
endmodule
